// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequencing controller around an iterative RV64 divider
// Prepares operands, short-circuits divide-by-zero/overflow, and holds the result until consumed.
module div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic        in_word,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic [4:0]  in_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_tag,
    output logic        div_in_valid,
    output logic [63:0] div_a,
    output logic [63:0] div_b,
    output logic        div_signed,
    output logic        div_flush,
    input  logic        div_result_valid,
    input  logic [63:0] div_quotient,
    input  logic [63:0] div_remainder
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic        start_q;
    logic        rem_q;
    logic        word_q;

    logic        accept;
    logic        op_signed;
    logic [63:0] a_prep, b_prep;
    logic        b_zero, ovf, special;
    logic [63:0] spec_quo, spec_rem;

    // W-variant results are always the sign-extension of the low word.
    function automatic logic [63:0] fmt_result(input logic [63:0] v, input logic w);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        op_signed = ~in_op[0];
        a_prep    = in_a;
        b_prep    = in_b;
        if (in_word) begin
            a_prep = op_signed ? {{32{in_a[31]}}, in_a[31:0]} : {32'h0, in_a[31:0]};
            b_prep = op_signed ? {{32{in_b[31]}}, in_b[31:0]} : {32'h0, in_b[31:0]};
        end
        b_zero  = (b_prep == 64'h0);
        ovf     = op_signed && (b_prep == {64{1'b1}}) &&
                  (in_word ? (a_prep == 64'hFFFF_FFFF_8000_0000)
                           : (a_prep == 64'h8000_0000_0000_0000));
        special = b_zero || ovf;
        spec_quo = b_zero ? {64{1'b1}} : a_prep;
        spec_rem = b_zero ? a_prep : 64'h0;
        accept  = in_valid && in_ready && !flush;
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign div_in_valid = start_q;
    assign div_flush    = flush && (state_q == RUN);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : RUN;
            RUN:     if (div_result_valid) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q    <= 1'b0;
            rem_q      <= 1'b0;
            word_q     <= 1'b0;
            out_result <= 64'h0;
            out_tag    <= 5'h0;
            div_a      <= 64'h0;
            div_b      <= 64'h0;
            div_signed <= 1'b0;
        end else begin
            start_q <= accept && !special;
            if (accept) begin
                rem_q      <= in_op[1];
                word_q     <= in_word;
                out_tag    <= in_tag;
                div_a      <= a_prep;
                div_b      <= b_prep;
                div_signed <= op_signed;
                if (special)
                    out_result <= fmt_result(in_op[1] ? spec_rem : spec_quo, in_word);
            end
            if (state_q == RUN && div_result_valid && !flush)
                out_result <= fmt_result(rem_q ? div_remainder : div_quotient, word_q);
            // A flushed operation leaves nothing behind for the consumer.
            if (flush) begin
                out_result <= 64'h0;
                out_tag    <= 5'h0;
            end
        end
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: all state is updated on the rising clk edge, and reset is sampled there.
REQ-002 SHALL expose these ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  sole clock
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; aborts any operation
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request
- in_op  in  2  00 div, 01 divu, 10 rem, 11 remu
- in_word  in  1  RV64 W-variant (32-bit operation)
- in_a  in  64  dividend
- in_b  in  64  divisor
- in_tag  in  5  destination register tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  64  final result
- out_tag  out  5  tag of the result
- div_in_valid  out  1  start pulse to the iterative divider
- div_a  out  64  divider dividend
- div_b  out  64  divider divisor
- div_signed  out  1  divider signed mode
- div_flush  out  1  divider abort
- div_result_valid  in  1  divider one-cycle done pulse
- div_quotient  in  64  divider quotient
- div_remainder  in  64  divider remainder

Function
REQ-003 SHALL implement the states IDLE, RUN and DONE.
REQ-004 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid&in_ready&!flush.
REQ-005 SHALL register op, word, tag and the prepared operands on accept.
- word=1, signed ops: operands are the sign-extended in_a[31:0] and in_b[31:0].
- word=1, unsigned ops: operands are the zero-extended in_a[31:0] and in_b[31:0].
REQ-006 SHALL detect special cases on the prepared operands at accept time.
- Divide by zero (b==0): quotient is all ones; remainder is a.
- Signed overflow (a is the most negative value of the operation width, b is all ones): quotient is a; remainder is 0.
REQ-007 On a special-case accept, SHALL go IDLE->DONE with the computed result; no div_in_valid is driven and latency is 1 cycle.
REQ-008 On a normal accept, SHALL go IDLE->RUN and assert div_in_valid for exactly one cycle, in the cycle after accept.
REQ-009 SHALL hold div_a, div_b and div_signed at the registered values from the div_in_valid cycle until the cycle div_result_valid is seen, inclusive.
- div_signed = (op==div | op==rem).
REQ-010 In RUN, when div_result_valid=1, SHALL capture the quotient for div/divu or the remainder for rem/remu, and go to DONE.
REQ-011 SHALL form the result for word=1 as the sign-extension of bit 31 of the selected 32-bit value, including for divu/remu.
REQ-012 In DONE, SHALL drive out_valid=1 with out_result and out_tag stable; DONE->IDLE when out_ready=1.
- in_ready is 0 in that cycle, so there is no back-to-back accept.
REQ-013 While out_valid=1 and out_ready=0, SHALL keep out_result and out_tag unchanged.
REQ-014 When flush=1 in any state, SHALL go to IDLE next cycle, drop any held result, and ignore a div_result_valid arriving in the same cycle.
REQ-015 SHALL assert div_flush combinationally equal to (flush & state==RUN).
REQ-016 SHALL give flush priority over accept, result capture and out_ready.
REQ-017 SHALL treat div_result_valid seen in IDLE or DONE as ignored, with no state change.

Reset
REQ-018 On reset, SHALL enter IDLE with in_ready=1 and all other outputs 0 (out_valid, out_result, out_tag, div_in_valid, div_a, div_b, div_signed).
- Exception: div_flush=0 by REQ-015.
REQ-019 Reset mid-RUN or mid-DONE SHALL abandon the operation; no out_valid is produced for it.

Verification
REQ-020 div, a=-7, b=2, word=0 -> one div_in_valid pulse, operands stable through the done pulse, out_result=-3, out_valid after the divider completes.
REQ-021 remu, word=1, a=0xFFFFFFFF_80000001, b=0x10 -> div_a=0x80000001, div_signed=0, result=1 sign-extended=0x1.
REQ-022 divu, a=5, b=0 -> out_valid the cycle after accept, out_result=0xFFFF_FFFF_FFFF_FFFF, div_in_valid never asserted.
REQ-023 div, word=1, a=0x80000000, b=-1 -> out_result=0xFFFF_FFFF_8000_0000, no divider start; rem same operands -> out_result=0.
REQ-024 flush at RUN cycle 10 -> div_flush=1 that cycle, IDLE next, no out_valid; a new request is accepted and completes correctly.
REQ-025 out_ready=0 for 5 cycles in DONE -> out_valid and out_result stable, in_ready=0; out_ready=1 -> IDLE next cycle.
